kip_kernel_dispatcher: RTL

Downstream of the KIP local formatter: consumes the formatted kernel stream (tdata/tkeep/tid/tdest/tuser/tlast) and delivers each packet to exactly one of NUM_KERNELS local kernel ports, selected by tdest.
- The destination is locked on the first beat and held until tlast.
- Packets addressed outside the local kernel range are consumed and discarded.
- The output is a single registered stage with full throughput.

---
 rtl/kip_kernel_dispatcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/kip_kernel_dispatcher.sv
// Routes each formatted kernel-stream packet to one local kernel port chosen by the header-beat tdest.
// Optional drop counter is built only when KIP_DISPATCH_DROP_CNT_EN is defined.
module kip_kernel_dispatcher #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = 64,
  parameter int AXIS_TDEST_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 48,
  parameter int NUM_KERNELS      = 4,
  parameter int KERNEL_BASE      = 0,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst,
  input  logic                        from_formatter_tvalid,
  output logic                        from_formatter_tready,
  input  logic                        from_formatter_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_formatter_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_formatter_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_formatter_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_formatter_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_formatter_tuser,
  output logic [NUM_KERNELS-1:0]      to_kernels_tvalid,
  input  logic [NUM_KERNELS-1:0]      to_kernels_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_kernels_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_kernels_tkeep,
  output logic [AXIS_TDEST_WIDTH-1:0] to_kernels_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] to_kernels_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_kernels_tuser,
  output logic                        to_kernels_tlast,
  output logic [DROP_CNT_WIDTH-1:0]   o_drop_count
);

  localparam int SEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int IW    = AXIS_TDEST_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic signed [IW-1:0] BASE_S = IW'(KERNEL_BASE);
  localparam logic signed [IW-1:0] NUM_S  = IW'(NUM_KERNELS);

  logic [1:0]             state;
  logic signed [IW-1:0]   idx;
  logic                   dest_valid;
  logic                   out_valid;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_ready;
  logic                   accept;
  logic                   load;

  // One extra bit keeps tdest below KERNEL_BASE negative instead of wrapping.
  assign idx        = $signed({1'b0, from_formatter_tdest}) - BASE_S;
  assign dest_valid = !idx[IW-1] && (idx < NUM_S);

  assign out_ready = to_kernels_tready[out_sel];

  assign from_formatter_tready = (state == S_DROP)
                               | ((state == S_IDLE) & !dest_valid)
                               | !out_valid
                               | out_ready;

  assign accept = from_formatter_tvalid & from_formatter_tready;
  assign load   = accept & ((state == S_FWD) | ((state == S_IDLE) & dest_valid));

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state <= S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (from_formatter_tlast) state <= S_IDLE;
          else if (dest_valid)      state <= S_FWD;
          else                      state <= S_DROP;
        end
        S_FWD, S_DROP: begin
          if (from_formatter_tlast) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The port lock and the output register's select are one register: it only
  // changes on a forwarded header beat, which is also when the register loads.
  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      out_valid        <= 1'b0;
      out_sel          <= '0;
      to_kernels_tdata <= '0;
      to_kernels_tkeep <= '0;
      to_kernels_tid   <= '0;
      to_kernels_tdest <= '0;
      to_kernels_tuser <= '0;
      to_kernels_tlast <= 1'b0;
    end else if (load) begin
      out_valid        <= 1'b1;
      if (state == S_IDLE) out_sel <= idx[SEL_W-1:0];
      to_kernels_tdata <= from_formatter_tdata;
      to_kernels_tkeep <= from_formatter_tkeep;
      to_kernels_tid   <= from_formatter_tid;
      to_kernels_tdest <= from_formatter_tdest;
      to_kernels_tuser <= from_formatter_tuser;
      to_kernels_tlast <= from_formatter_tlast;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign to_kernels_tvalid = out_valid ? (NUM_KERNELS'(1) << out_sel) : '0;

`ifdef KIP_DISPATCH_DROP_CNT_EN
  logic                      drop_hdr;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  assign drop_hdr = accept & (state == S_IDLE) & !dest_valid;

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      drop_count <= '0;
    end else if (drop_hdr && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign o_drop_count = drop_count;
`else
  assign o_drop_count = '0;
`endif

endmodule
